aes_round_ctrl: RTL and testbench
=================================

// Module: aes_round_ctrl
// PURPOSE
//  Iterative AES encryption round sequencer. Accepts one 4*Nb-byte plaintext block, applies the
//  initial AddRoundKey, then runs Nr rounds through a single shared round datapath and presents
//  the ciphertext. Sits between the block-level I/O handshake and the round-key store.
//  The round-key store supplies key words by index. One block in flight at a time.
// PARAMETERS
//  NB   aes_const::Nb  columns per state (4); state is 4*NB bytes
//  NR   aes_const::Nr  number of rounds (10/12/14); round counter width = $clog2(NR+1)
// PORTS
//  clock      in   1             rising-edge clock
//  reset      in   1             synchronous, active-high reset
//  in_valid   in   1             plaintext block valid
//  in_ready   out  1             block can be accepted
//  in_data    in   [7:0]x4*NB    plaintext, byte 4*j+i = row i, column j
//  rkey_idx   out  4             round-key index requested (0..NR)
//  rkey       in   [7:0]x4*NB    round key for rkey_idx, combinational, same cycle
//  out_valid  out  1             ciphertext valid
//  out_ready  in   1             consumer accepts ciphertext
//  out_data   out  [7:0]x4*NB    ciphertext, same byte order as in_data
//  blk_cnt    out  32            blocks completed (AES_BLK_CNT_EN only)
// BEHAVIOUR
//  Reset: FSM=IDLE, round=0, state_q=0, in_ready=1, out_valid=0, out_data=0, rkey_idx=0, blk_cnt=0.
//  FSM states:
//   IDLE: in_ready=1, rkey_idx=0. When in_valid=1, state_q<=in_data^rkey, round<=1 and go to RUN.
//   RUN: in_ready=0, rkey_idx=round. Each cycle, state_q<=round_dp(state_q,rkey,last) and round++.
//     The signal last=(round==NR). When last=1, go to DONE.
//   DONE: out_valid=1, out_data=state_q. Hold out_data stable while out_ready=0.
//     When out_ready=1, go to IDLE; out_valid drops the next cycle.
//  Round datapath, combinational, in order: SubBytes -> ShiftRows -> MixColumns -> AddRoundKey.
//   MixColumns is bypassed when last=1.
//  Latency: accept at cycle T -> out_valid=1 at T+NR+1. 11 cycles for AES-128.
//  Throughput: one block per NR+2 cycles when out_ready is held 1.
//  in_ready is combinational from FSM only (in_ready==(FSM==IDLE)). No dependency on in_valid.
//  in_valid while in RUN/DONE is ignored and the data is not captured; the source must hold it.
//  No accept in the DONE->IDLE cycle: an output handshake and an input accept never coincide.
//  reset=1 in any state aborts the block: next cycle is the reset state, and no partial out_valid.
//  Round counter never exceeds NR. rkey_idx is zero-extended from round.
// CONFIGURATION
//  AES_BLK_CNT_EN defined: blk_cnt port exists and increments by 1 on each out_valid&&out_ready.
//   It wraps 2^32-1 -> 0 and is cleared by reset.
//  AES_BLK_CNT_EN undefined: blk_cnt port and counter are absent. All other behaviour is identical.
// STRUCTURE
//  aes_const: Nb, Nk, Nr, and the typedef state_t = logic [7:0] [0:4*Nb-1].
//  aes_wire: FSM enum ctrl_state_t {IDLE, RUN, DONE}.
//  Sub-module aes_round_dp (state_in, rkey, last -> state_out): a purely combinational round.
//   It instantiates the existing SubBytes/ShiftRows/MixColumns blocks.
//  aes_round_ctrl holds only the FSM, round counter, state register and optional counter.
// TESTING
//  FIPS-197 C.1: key 000102..0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a.
//   out_valid must rise exactly 11 cycles after accept.
//  rkey_idx trace for the C.1 block: 0 at accept, then 1,2,...,10 on consecutive cycles.
//   Then DONE with round held.
//  Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and out_data stable, in_ready=0.
//   Then out_ready=1 -> IDLE next cycle.
//  Busy input: in_valid=1 with pt FF..FF during RUN -> not captured.
//   The C.1 ciphertext is still produced; FF..FF is accepted only after return to IDLE.
//  Mid-op reset: reset=1 at round 5 -> next cycle in_ready=1, out_valid=0, rkey_idx=0.
//   A new C.1 block then still yields 69c4...c55a.
//  AES_BLK_CNT_EN: 3 back-to-back blocks with out_ready=1 -> blk_cnt=3.
//   Preload/force blk_cnt=FFFFFFFF plus one block -> blk_cnt=0.

Source files
------------

// File: rtl/aes_round_ctrl_pkg.sv
// rtl/aes_round_ctrl_pkg.sv - AES constants, state type, FSM encodings and GF(2^8) helpers
package aes_round_ctrl_pkg;

    localparam int Nb = 4;
    localparam int Nk = 4;
    localparam int Nr = Nk + 6;

    // Byte 4*j+i (row i, column j) is element j*4+i; element 0 is the most significant byte.
    typedef logic [0:4*Nb-1][7:0] state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as SubBytes requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gf_mul(r, sq);
            sq = gf_mul(sq, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_round_dp.sv
// rtl/aes_round_dp.sv - combinational AES round: SubBytes, ShiftRows, MixColumns, AddRoundKey
//
// Ports:
//   state_in   [32*NB-1:0]  round input state, byte 0 in the MSBs
//   rkey       [32*NB-1:0]  round key for this round
//   last                    final round: MixColumns bypassed
//   state_out  [32*NB-1:0]  round output state
module aes_round_dp
    import aes_round_ctrl_pkg::*;
#(
    parameter int NB = Nb
) (
    input  logic [32*NB-1:0] state_in,
    input  logic [32*NB-1:0] rkey,
    input  logic             last,
    output logic [32*NB-1:0] state_out
);

    logic [0:4*NB-1][7:0] s_in;
    logic [0:4*NB-1][7:0] s_sb;
    logic [0:4*NB-1][7:0] s_sr;
    logic [0:4*NB-1][7:0] s_mc;

    assign s_in = state_in;

    always_comb begin
        s_sb = '0;
        s_sr = '0;
        s_mc = '0;
        for (int k = 0; k < 4*NB; k++) begin
            s_sb[k] = sbox(s_in[k]);
        end
        // Row i rotates left by i columns.
        for (int j = 0; j < NB; j++) begin
            for (int i = 0; i < 4; i++) begin
                s_sr[4*j+i] = s_sb[4*((j+i)%NB)+i];
            end
        end
        for (int j = 0; j < NB; j++) begin
            s_mc[4*j+0] = xtime(s_sr[4*j+0]) ^ xtime(s_sr[4*j+1]) ^ s_sr[4*j+1]
                        ^ s_sr[4*j+2] ^ s_sr[4*j+3];
            s_mc[4*j+1] = s_sr[4*j+0] ^ xtime(s_sr[4*j+1]) ^ xtime(s_sr[4*j+2])
                        ^ s_sr[4*j+2] ^ s_sr[4*j+3];
            s_mc[4*j+2] = s_sr[4*j+0] ^ s_sr[4*j+1] ^ xtime(s_sr[4*j+2])
                        ^ xtime(s_sr[4*j+3]) ^ s_sr[4*j+3];
            s_mc[4*j+3] = xtime(s_sr[4*j+0]) ^ s_sr[4*j+0] ^ s_sr[4*j+1]
                        ^ s_sr[4*j+2] ^ xtime(s_sr[4*j+3]);
        end
    end

    assign state_out = (last ? s_sr : s_mc) ^ rkey;

endmodule

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - iterative AES encryption round sequencer, one block in flight
//
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    plaintext handshake; in_ready depends on the FSM only
//   in_data              plaintext, byte 4*j+i (row i, column j) at bits [32*NB-1-8*(4*j+i) -: 8]
//   rkey_idx/rkey        round-key index out, round key back in the same cycle
//   out_valid/out_ready  ciphertext handshake; out_data held stable while stalled
//   out_data             ciphertext, same byte order as in_data
//   blk_cnt              completed-block counter, present only when AES_BLK_CNT_EN is defined
module aes_round_ctrl
    import aes_round_ctrl_pkg::*;
#(
    parameter int NB = Nb,
    parameter int NR = Nr
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [32*NB-1:0] in_data,
    output logic [3:0]       rkey_idx,
    input  logic [32*NB-1:0] rkey,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [32*NB-1:0] out_data
`ifdef AES_BLK_CNT_EN
    ,
    output logic [31:0]      blk_cnt
`endif
);

    localparam int RW = $clog2(NR + 1);

    logic [1:0]       fsm_q;
    logic [RW-1:0]    round_q;
    logic [32*NB-1:0] state_q;
    logic [32*NB-1:0] dp_out;
    logic             last;

    assign last      = (round_q == RW'(NR));
    assign in_ready  = (fsm_q == ST_IDLE);
    assign out_valid = (fsm_q == ST_DONE);
    assign out_data  = out_valid ? state_q : '0;
    // round_q is 0 in IDLE, so the initial whitening key is index 0 there.
    assign rkey_idx  = 4'(round_q);

    aes_round_dp #(
        .NB (NB)
    ) u_round_dp (
        .state_in  (state_q),
        .rkey      (rkey),
        .last      (last),
        .state_out (dp_out)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_q   <= ST_IDLE;
            round_q <= '0;
            state_q <= '0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_q <= in_data ^ rkey;
                        round_q <= RW'(1);
                        fsm_q   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    state_q <= dp_out;
                    // Counter saturates at NR so DONE still reports the final index.
                    if (last) begin
                        fsm_q <= ST_DONE;
                    end else begin
                        round_q <= round_q + RW'(1);
                    end
                end
                ST_DONE: begin
                    // Returning through IDLE keeps an output handshake and an accept apart.
                    if (out_ready) begin
                        fsm_q   <= ST_IDLE;
                        round_q <= '0;
                    end
                end
                default: begin
                    fsm_q   <= ST_IDLE;
                    round_q <= '0;
                end
            endcase
        end
    end

`ifdef AES_BLK_CNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            blk_cnt <= '0;
        end else if (out_valid && out_ready) begin
            blk_cnt <= blk_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - scoreboard bench for aes_round_ctrl with a table-based AES model
module tb_aes_round_ctrl;

    localparam int NR_T = 10;
    localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] ALL_F = {128{1'b1}};

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   rkey_idx;
    logic [127:0] rkey;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
`ifdef AES_BLK_CNT_EN
    logic [31:0]  blk_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit rnd_bp = 1'b0;
    logic [127:0] exp_q[$];
    logic [127:0] rk [16];

    logic [127:0] sbox_rows [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    aes_round_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rkey_idx  (rkey_idx),
        .rkey      (rkey),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef AES_BLK_CNT_EN
        ,
        .blk_cnt   (blk_cnt)
`endif
    );

    // Round-key store: combinational lookup by the requested index.
    assign rkey = rk[rkey_idx];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [7:0] sb(input logic [7:0] b);
        logic [127:0] row;
        row = sbox_rows[b[7:4]];
        return row[127-8*int'(b[3:0]) -: 8];
    endfunction

    function automatic logic [7:0] mul2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] ref_enc(input logic [127:0] pt);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] k;
        logic [127:0] res;
        k = rk[0];
        for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ k[127-8*n -: 8];
        for (int r = 1; r <= NR_T; r++) begin
            k = rk[r];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[4*c+row] = sb(s[4*((c+row)%4)+row]);
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r == NR_T) begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end else begin
                    s[4*c]   = mul2(a0) ^ mul2(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ mul2(a1) ^ mul2(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ mul2(a2) ^ mul2(a3) ^ a3;
                    s[4*c+3] = mul2(a0) ^ a0 ^ a1 ^ a2 ^ mul2(a3);
                end
            end
            for (int n = 0; n < 16; n++) s[n] = s[n] ^ k[127-8*n -: 8];
        end
        for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
        return res;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Called at a negedge; holds in_valid until accepted, returns at the negedge after accept.
    task automatic send(input logic [127:0] pt, input logic [127:0] ct, output int acc);
        int waited = 0;
        acc = -1;
        in_valid = 1'b1;
        in_data  = pt;
        while (!in_ready && waited < 100) begin
            if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
            @(negedge clock);
            waited++;
        end
        if (in_ready) begin
            exp_q.push_back(ct);
            acc = cyc;
        end else begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout got=in_ready_low exp=accept");
        end
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 300) begin
            @(negedge clock);
            waited++;
        end
        check("drain_pending", 128'(exp_q.size()), 128'd0);
    endtask

    // Monitor: samples just after the negedge so it sees the same out_ready the next posedge uses.
    always begin
        @(negedge clock);
        #1;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", out_data, 128'hx);
            end else begin
                check("ciphertext", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   rcon;
        logic [127:0] key;
        logic [127:0] pt;
        int           acc1;
        int           acc2;
        int           waited;

        key  = 128'h000102030405060708090a0b0c0d0e0f;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp  = {sb(tmp[23:16]), sb(tmp[15:8]), sb(tmp[7:0]), sb(tmp[31:24])} ^ {rcon, 24'h0};
                rcon = mul2(rcon);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 16; r++) rk[r] = (r <= NR_T) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;

        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_in_ready",  128'(in_ready),  128'd1);
        check("reset_out_valid", 128'(out_valid), 128'd0);
        check("reset_rkey_idx",  128'(rkey_idx),  128'd0);
        check("reset_out_data",  out_data,        128'd0);
        reset = 1'b0;

        // FIPS-197 C.1 with key index trace and latency.
        out_ready = 1'b1;
        @(negedge clock);
        check("idle_rkey_idx", 128'(rkey_idx), 128'd0);
        send(C1_PT, C1_CT, acc1);
        for (int r = 1; r <= NR_T; r++) begin
            check("run_trace", 128'({out_valid, rkey_idx}), 128'({1'b0, 4'(r)}));
            @(negedge clock);
        end
        check("c1_out_valid",  128'(out_valid),  128'd1);
        check("c1_latency",    128'(cyc - acc1), 128'd11);
        check("done_rkey_idx", 128'(rkey_idx),   128'(NR_T));
        drain();

        // Backpressure in DONE.
        out_ready = 1'b0;
        send(C1_PT, C1_CT, acc1);
        waited = 0;
        while (!out_valid && waited < 30) begin
            @(negedge clock);
            waited++;
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 128'(out_valid), 128'd1);
            check("bp_out_data",  out_data,        C1_CT);
            check("bp_in_ready",  128'(in_ready),  128'd0);
            @(negedge clock);
        end
        out_ready = 1'b1;
        @(negedge clock);
        check("bp_release_in_ready",  128'(in_ready),  128'd1);
        check("bp_release_out_valid", 128'(out_valid), 128'd0);
        drain();

        // in_valid held during RUN must not be captured until IDLE.
        send(C1_PT, C1_CT, acc1);
        send(ALL_F, ref_enc(ALL_F), acc2);
        check("busy_accept_gap", 128'(acc2 - acc1), 128'(NR_T + 2));
        drain();

        // Abort at round 5.
        send(C1_PT, C1_CT, acc1);
        repeat (4) @(negedge clock);
        check("abort_round", 128'(rkey_idx), 128'd5);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        check("abort_in_ready",  128'(in_ready),  128'd1);
        check("abort_out_valid", 128'(out_valid), 128'd0);
        check("abort_rkey_idx",  128'(rkey_idx),  128'd0);
        send(C1_PT, C1_CT, acc1);
        drain();

        // Randomized plaintexts and backpressure.
        rnd_bp = 1'b1;
        for (int n = 0; n < 24; n++) begin
            if (n == 0) pt = '0;
            else if (n == 1) pt = ALL_F;
            else pt = {$urandom, $urandom, $urandom, $urandom};
            send(pt, ref_enc(pt), acc1);
            repeat ($urandom_range(0, 3)) begin
                out_ready = 1'($urandom_range(0, 1));
                @(negedge clock);
            end
        end
        rnd_bp = 1'b0;
        out_ready = 1'b1;
        drain();

`ifdef AES_BLK_CNT_EN
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        check("blk_cnt_reset", 128'(blk_cnt), 128'd0);
        for (int n = 0; n < 3; n++) send(C1_PT, C1_CT, acc1);
        drain();
        @(negedge clock);
        check("blk_cnt_three", 128'(blk_cnt), 128'd3);
`endif

        @(negedge clock);
        check("final_idle", 128'({in_ready, out_valid}), 128'd2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
